// File: rtl/ndma_ch_regs.sv
// Register file for the NDMA channels: OBI subordinate, per-channel SRC/DST/LEN/CTRL, IRQ pend/enable.
// Define NDMA_REG_ERR_EN to report unmapped, busy-write and rejected-start accesses on err_o.
module ndma_ch_regs #(
  parameter int unsigned NumCh    = 4,
  parameter int unsigned LenWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [NumCh*32-1:0]       src_addr_o,
  output logic [NumCh*32-1:0]       dst_addr_o,
  output logic [NumCh*LenWidth-1:0] tx_len_o,
  output logic [NumCh-1:0]          start_o,
  input  logic [NumCh-1:0]          done_i,
  output logic                      irq_o
);

`ifdef NDMA_REG_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic [NumCh-1:0][31:0]       r_src, r_dst;
  logic [NumCh-1:0][LenWidth-1:0] r_len;
  logic [NumCh-1:0]             r_busy, r_done, r_pend, r_en, r_start;
  logic                         r_rvalid, r_err, r_irq;
  logic [31:0]                  r_rdata;

  logic [31:0]      w_bemask, w_rdata;
  logic             w_wr, w_err, w_glb_pend, w_glb_en, w_wr_en;
  logic [NumCh-1:0] w_ch_sel, w_start, w_clr_done, w_wr_src, w_wr_dst, w_wr_len;
  logic [NumCh-1:0] w_pend_clr, w_done_ev;
  logic             w_unused_addr;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  assign gnt_o         = req_i;
  assign w_wr          = req_i & we_i;
  assign w_bemask      = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_glb_pend    = addr_i[8] && (addr_i[7:2] == 6'h00);
  assign w_glb_en      = addr_i[8] && (addr_i[7:2] == 6'h01);
  assign w_done_ev     = done_i & r_busy;
  assign w_unused_addr = ^{addr_i[31:9], addr_i[1:0]};

  always_comb begin
    w_ch_sel = '0;
    for (int unsigned n = 0; n < NumCh; n++) begin
      w_ch_sel[n] = !addr_i[8] && (addr_i[7:4] == 4'(n));
    end
  end

  always_comb begin
    w_rdata    = '0;
    w_err      = 1'b0;
    w_start    = '0;
    w_clr_done = '0;
    w_wr_src   = '0;
    w_wr_dst   = '0;
    w_wr_len   = '0;
    w_pend_clr = '0;
    w_wr_en    = 1'b0;
    for (int unsigned n = 0; n < NumCh; n++) begin
      if (w_ch_sel[n]) begin
        case (addr_i[3:2])
          2'd0: begin
            w_rdata = {r_busy[n], r_done[n], 30'b0};
            if (w_wr && be_i[0] && wdata_i[0]) begin
              if (!r_busy[n] && (r_len[n] != '0)) w_start[n] = 1'b1;
              else                                 w_err      = 1'b1;
            end
            w_clr_done[n] = w_wr & be_i[3] & wdata_i[30];
          end
          2'd1: begin
            w_rdata = r_src[n];
            if (w_wr) begin
              if (r_busy[n]) w_err       = 1'b1;
              else           w_wr_src[n] = 1'b1;
            end
          end
          2'd2: begin
            w_rdata = r_dst[n];
            if (w_wr) begin
              if (r_busy[n]) w_err       = 1'b1;
              else           w_wr_dst[n] = 1'b1;
            end
          end
          default: begin
            w_rdata = 32'(r_len[n]);
            if (w_wr) begin
              if (r_busy[n]) w_err       = 1'b1;
              else           w_wr_len[n] = 1'b1;
            end
          end
        endcase
      end
    end
    if (w_glb_pend) begin
      w_rdata[NumCh-1:0] = r_pend;
      if (w_wr && be_i[0]) w_pend_clr = wdata_i[NumCh-1:0];
    end
    if (w_glb_en) begin
      w_rdata[NumCh-1:0] = r_en;
      w_wr_en            = w_wr;
    end
    if (!(|w_ch_sel || w_glb_pend || w_glb_en)) w_err = 1'b1;
    if (we_i) w_rdata = '0;
  end

  // A done event wins over a same-cycle W1C or done-clear on the same bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_busy   <= '0;
      r_done   <= '0;
      r_pend   <= '0;
      r_en     <= '0;
      r_start  <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= req_i ? w_rdata : '0;
      r_err    <= req_i & w_err & ErrEn;
      r_start  <= w_start;
      r_busy   <= (r_busy & ~w_done_ev) | w_start;
      r_done   <= (r_done & ~w_clr_done) | w_done_ev;
      r_pend   <= (r_pend & ~w_pend_clr) | w_done_ev;
      r_irq    <= |(r_pend & r_en);
      if (w_wr_en) begin
        r_en <= (r_en & ~w_bemask[NumCh-1:0]) | (wdata_i[NumCh-1:0] & w_bemask[NumCh-1:0]);
      end
      for (int unsigned n = 0; n < NumCh; n++) begin
        if (w_wr_src[n]) r_src[n] <= f_merge(r_src[n], wdata_i, w_bemask);
        if (w_wr_dst[n]) r_dst[n] <= f_merge(r_dst[n], wdata_i, w_bemask);
        if (w_wr_len[n]) r_len[n] <= LenWidth'(f_merge(32'(r_len[n]), wdata_i, w_bemask));
      end
    end
  end

  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign err_o      = r_err;
  assign start_o    = r_start;
  assign irq_o      = r_irq;
  assign src_addr_o = r_src;
  assign dst_addr_o = r_dst;
  assign tx_len_o   = r_len;

endmodule

// File: tb/tb_ndma_ch_regs.sv
// Directed bench for ndma_ch_regs (NumCh=2); responses are checked against a queue of expected read data/err.
module tb_ndma_ch_regs;
  localparam int unsigned NumCh    = 2;
  localparam int unsigned LenWidth = 16;
`ifdef NDMA_REG_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  logic                      clk_i   = 1'b0;
  logic                      rst_ni  = 1'b1;
  logic                      req_i   = 1'b0;
  logic                      we_i    = 1'b0;
  logic [3:0]                be_i    = '0;
  logic [31:0]               addr_i  = '0;
  logic [31:0]               wdata_i = '0;
  logic                      gnt_o, rvalid_o, err_o, irq_o;
  logic [31:0]               rdata_o;
  logic [NumCh*32-1:0]       src_addr_o, dst_addr_o;
  logic [NumCh*LenWidth-1:0] tx_len_o;
  logic [NumCh-1:0]          start_o;
  logic [NumCh-1:0]          done_i  = '0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  ndma_ch_regs #(.NumCh(NumCh), .LenWidth(LenWidth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .tx_len_o(tx_len_o), .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the next negedge with the response on the bus.
  task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] erd, input logic eerr);
    exp_t e;
    e.rd = erd; e.err = eerr; e.addr = addr;
    exp_q.push_back(e);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = data;
    #1 check("gnt", 64'(gnt_o), 64'd1);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic eerr);
    bus(1'b1, 4'hF, addr, data, 32'h0, eerr);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] erd, input logic eerr);
    bus(1'b0, 4'hF, addr, 32'h0, erd, eerr);
  endtask

  always @(negedge clk_i) begin
    if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 64'(rvalid_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rdata@%h", e.addr), 64'(rdata_o), 64'(e.rd));
        check($sformatf("err@%h", e.addr), 64'(err_o), 64'(e.err));
      end
    end else begin
      check("rdata_idle", 64'(rdata_o), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_src"}, 64'(src_addr_o), 64'd0);
    check({tag, "_dst"}, 64'(dst_addr_o), 64'd0);
    check({tag, "_len"}, 64'(tx_len_o), 64'd0);
    check({tag, "_start"}, 64'(start_o), 64'd0);
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    check({tag, "_rdata"}, 64'(rdata_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_irq"}, 64'(irq_o), 64'd0);
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    tick();
    check_all_zero("rst");
    rst_ni = 1'b1;
    tick();
    rd(32'h000, 32'h0, 1'b0);
    rd(32'h104, 32'h0, 1'b0);
    rd(32'h100, 32'h0, 1'b0);

    // Channel 0 programming and start
    wr(32'h004, 32'h1000_0000, 1'b0);
    wr(32'h008, 32'h2000_0000, 1'b0);
    wr(32'h00C, 32'h0000_0040, 1'b0);
    check("src0_out", 64'(src_addr_o[31:0]), 64'h1000_0000);
    check("dst0_out", 64'(dst_addr_o[31:0]), 64'h2000_0000);
    check("len0_out", 64'(tx_len_o[15:0]), 64'h40);
    wr(32'h000, 32'h1, 1'b0);
    check("start0_pulse", 64'(start_o), 64'b01);
    rd(32'h000, 32'h8000_0000, 1'b0);
    check("start0_once", 64'(start_o), 64'b00);
    wr(32'h00C, 32'h99, EE);
    check("len0_busy_hold", 64'(tx_len_o[15:0]), 64'h40);
    rd(32'h00C, 32'h40, 1'b0);

    // Channel 1 concurrent; writes while busy
    wr(32'h014, 32'h1111_0000, 1'b0);
    wr(32'h01C, 32'h8, 1'b0);
    wr(32'h010, 32'h1, 1'b0);
    check("start1_pulse", 64'(start_o), 64'b10);
    wr(32'h014, 32'hDEAD_BEEF, EE);
    check("src1_busy_hold", 64'(src_addr_o[63:32]), 64'h1111_0000);
    check("start1_once", 64'(start_o), 64'b00);
    rd(32'h014, 32'h1111_0000, 1'b0);
    wr(32'h010, 32'h1, EE);
    check("start1_busy_reject", 64'(start_o), 64'b00);

    // IRQ path
    wr(32'h104, 32'h3, 1'b0);
    rd(32'h104, 32'h3, 1'b0);
    done_i = 2'b10;
    tick();
    done_i = 2'b00;
    tick();
    check("irq_set", 64'(irq_o), 64'd1);
    rd(32'h100, 32'h2, 1'b0);
    rd(32'h010, 32'h4000_0000, 1'b0);
    wr(32'h100, 32'h2, 1'b0);
    tick();
    check("irq_clr", 64'(irq_o), 64'd0);
    rd(32'h100, 32'h0, 1'b0);
    wr(32'h010, 32'h4000_0000, 1'b0);
    rd(32'h010, 32'h0, 1'b0);

    // done_i and W1C on the same bit in the same cycle
    done_i = 2'b01;
    wr(32'h100, 32'h1, 1'b0);
    done_i = 2'b00;
    rd(32'h100, 32'h1, 1'b0);
    check("irq_done_w1c", 64'(irq_o), 64'd1);
    rd(32'h000, 32'h4000_0000, 1'b0);

    // start command in the same cycle as done_i
    wr(32'h000, 32'h1, 1'b0);
    check("start0_restart", 64'(start_o), 64'b01);
    done_i = 2'b01;
    wr(32'h000, 32'h1, EE);
    done_i = 2'b00;
    check("start0_done_same", 64'(start_o), 64'b00);
    tick();
    check("start0_done_after", 64'(start_o), 64'b00);
    rd(32'h000, 32'h4000_0000, 1'b0);
    wr(32'h100, 32'h3, 1'b0);
    tick();
    check("irq_clr_all", 64'(irq_o), 64'd0);

    // Unmapped and aliased addresses
    rd(32'h020, 32'h0, EE);
    wr(32'h024, 32'h1234_5678, EE);
    rd(32'h108, 32'h0, EE);
    rd(32'h1FC, 32'h0, EE);
    rd(32'hABCD_E105, 32'h3, 1'b0);

    // Byte enables and LEN width
    bus(1'b1, 4'b0101, 32'h004, 32'hAABB_CCDD, 32'h0, 1'b0);
    rd(32'h004, 32'h10BB_00DD, 1'b0);
    wr(32'h00C, 32'hFFFF_FFFF, 1'b0);
    rd(32'h00C, 32'h0000_FFFF, 1'b0);
    check("len0_full", 64'(tx_len_o[15:0]), 64'hFFFF);
    bus(1'b1, 4'b0010, 32'h00C, 32'h0000_1200, 32'h0, 1'b0);
    rd(32'h00C, 32'h0000_12FF, 1'b0);

    // Zero length start and idle done_i
    wr(32'h00C, 32'h0, 1'b0);
    wr(32'h000, 32'h1, EE);
    check("start0_len0", 64'(start_o), 64'b00);
    rd(32'h000, 32'h4000_0000, 1'b0);
    done_i = 2'b10;
    tick();
    done_i = 2'b00;
    rd(32'h100, 32'h0, 1'b0);
    rd(32'h010, 32'h0, 1'b0);

    // Reset in the middle of a transfer
    wr(32'h01C, 32'h5, 1'b0);
    wr(32'h010, 32'h1, 1'b0);
    check("start1_again", 64'(start_o), 64'b10);
    tick();
    rst_ni = 1'b0;
    #1 check_all_zero("midrst");
    tick();
    rst_ni = 1'b1;
    done_i = 2'b10;
    tick();
    done_i = 2'b00;
    rd(32'h100, 32'h0, 1'b0);
    rd(32'h010, 32'h0, 1'b0);
    rd(32'h104, 32'h0, 1'b0);
    rd(32'h01C, 32'h0, 1'b0);
    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
